// File: rtl/apb_master_bridge.sv
// Request/response to APB master bridge: one transfer in flight, SETUP -> ACCESS -> RESP.
// Minimum three cycles accept-to-response; RESP holds under rsp_ready_i backpressure; optional ACCESS timeout.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic                      pwrite_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_req_ready;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;
  logic                      r_timeout;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_accept;
  logic                      w_timeout_hit;

  assign w_accept      = r_req_ready & req_valid_i;
  // r_cnt holds the number of earlier stalled ACCESS cycles, so this is the last allowed one
  assign w_timeout_hit = TO_EN && (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (pready_i || w_timeout_hit) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_addr  <= req_addr_i;
        r_write <= req_write_i;
        r_wdata <= req_wdata_i;
        r_cnt   <= '0;
      end
      if (r_state == ACCESS) begin
        if (pready_i) begin
          r_err     <= pslverr_i;
          r_rdata   <= r_write ? '0 : prdata_i;
          r_timeout <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout_hit) begin
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_timeout <= 1'b1;
          end
        end
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them in the same cycle
  assign psel_o        = (r_state == SETUP) || (r_state == ACCESS);
  assign penable_o     = (r_state == ACCESS);
  assign rsp_valid_o   = (r_state == RESP);
  assign req_ready_o   = r_req_ready;
  assign paddr_o       = r_addr;
  assign pwrite_o      = r_write;
  assign pwdata_o      = r_wdata;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, reset/back-to-back sequences, random transfers vs a transaction model.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk_i = ~clk_i;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;   // stalled ACCESS cycles before pready
    logic        slverr;
    logic [31:0] prdata;
    int          dly;     // cycles rsp_ready_i is held low
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
    int          exp_acc; // expected number of ACCESS cycles
  } vec_t;

  vec_t tbl [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level outcome from the protocol rules
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (TO > 0 && v.waits >= TO) begin
      r.exp_acc = TO; r.exp_err = 1'b1; r.exp_to = 1'b1; r.exp_rdata = '0;
    end else begin
      r.exp_acc = v.waits + 1; r.exp_err = v.slverr; r.exp_to = 1'b0;
      r.exp_rdata = v.write ? 32'h0 : v.prdata;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic xfer(input vec_t v);
    chk1("idle_req_ready", req_ready_o, 1'b1);
    chk1("idle_psel", psel_o, 1'b0);
    chk1("idle_rsp_valid", rsp_valid_o, 1'b0);
    req_valid_i = 1'b1; req_addr_i = v.addr; req_write_i = v.write; req_wdata_i = v.wdata;
    step();
    // SETUP: garbage on req_* and APB inputs must be ignored
    req_valid_i = 1'b0; req_addr_i = $urandom; req_write_i = 1'($urandom); req_wdata_i = $urandom;
    pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
    chk1("setup_psel", psel_o, 1'b1);
    chk1("setup_penable", penable_o, 1'b0);
    chk1("setup_req_ready", req_ready_o, 1'b0);
    chk32("setup_paddr", paddr_o, v.addr);
    chk1("setup_pwrite", pwrite_o, v.write);
    chk32("setup_pwdata", pwdata_o, v.wdata);
    step();
    for (int k = 0; k < v.exp_acc; k++) begin
      chk1("acc_psel", psel_o, 1'b1);
      chk1("acc_penable", penable_o, 1'b1);
      chk1("acc_rsp_valid", rsp_valid_o, 1'b0);
      chk32("acc_paddr", paddr_o, v.addr);
      chk1("acc_pwrite", pwrite_o, v.write);
      chk32("acc_pwdata", pwdata_o, v.wdata);
      pready_i  = (k == v.waits);
      pslverr_i = (k == v.waits) ? v.slverr : 1'($urandom);
      prdata_i  = (k == v.waits) ? v.prdata : $urandom;
      step();
    end
    for (int d = 0; d <= v.dly; d++) begin
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
      chk1("rsp_valid", rsp_valid_o, 1'b1);
      chk32("rsp_rdata", rsp_rdata_o, v.exp_rdata);
      chk1("rsp_err", rsp_err_o, v.exp_err);
      chk1("rsp_timeout", rsp_timeout_o, v.exp_to);
      chk1("rsp_psel", psel_o, 1'b0);
      chk1("rsp_penable", penable_o, 1'b0);
      chk1("rsp_req_ready", req_ready_o, 1'b0);
      chk32("rsp_paddr_hold", paddr_o, v.addr);
      if (d < v.dly) begin
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = $urandom;
      end else begin
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
      end
      step();
    end
    rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    chk1("post_rsp_valid", rsp_valid_o, 1'b0);
    chk1("post_psel", psel_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int setups, rsps, last_setup;

    tbl[0] = '{32'h1000_0004, 1'b0, 32'h0,        0,  1'b0, 32'hDEADBEEF, 0,  1'b0, 1'b0, 32'hDEADBEEF, 1};
    tbl[1] = '{32'h3000_0010, 1'b1, 32'h12345678, 3,  1'b1, 32'h5555AAAA, 0,  1'b1, 1'b0, 32'h0,        4};
    tbl[2] = '{32'h2000_0000, 1'b0, 32'h0,        40, 1'b0, 32'h11111111, 0,  1'b1, 1'b1, 32'h0,        16};
    tbl[3] = '{32'h2000_0008, 1'b0, 32'h0,        15, 1'b0, 32'hA5A5A5A5, 0,  1'b0, 1'b0, 32'hA5A5A5A5, 16};
    tbl[4] = '{32'h4000_0020, 1'b1, 32'hCAFEF00D, 0,  1'b0, 32'h77777777, 10, 1'b0, 1'b0, 32'h0,        1};
    tbl[5] = '{32'h5000_0000, 1'b0, 32'h0,        1,  1'b1, 32'h0F0F0F0F, 2,  1'b1, 1'b0, 32'h0F0F0F0F, 2};

    #1;
    chk1("rst_req_ready", req_ready_o, 1'b0);
    chk1("rst_psel", psel_o, 1'b0);
    chk1("rst_penable", penable_o, 1'b0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk1("rst_rsp_err", rsp_err_o, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    chk32("rst_paddr", paddr_o, 32'h0);
    chk32("rst_pwdata", pwdata_o, 32'h0);
    chk32("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk1("rst_pwrite", pwrite_o, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk1("rst_release_ready_low", req_ready_o, 1'b0);
    step();

    for (int i = 0; i < 6; i++) xfer(tbl[i]);

    // Reset during ACCESS
    req_valid_i = 1'b1; req_addr_i = 32'h6000_0000; req_write_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    step();
    chk1("pre_rst_penable", penable_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk1("midrst_psel", psel_o, 1'b0);
    chk1("midrst_penable", penable_o, 1'b0);
    chk1("midrst_req_ready", req_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk1("midrst_rsp_valid", rsp_valid_o, 1'b0);
    end
    rst_i = 1'b0;
    step();
    chk1("midrst_rsp_valid_after", rsp_valid_o, 1'b0);
    xfer(tbl[0]);

    // Back-to-back with rsp_ready tied high
    req_valid_i = 1'b1; req_addr_i = 32'h7000_0000; req_write_i = 1'b1; req_wdata_i = 32'h1;
    rsp_ready_i = 1'b1; pready_i = 1'b1; pslverr_i = 1'b0;
    setups = 0; rsps = 0; last_setup = -1;
    for (int i = 0; i < 16; i++) begin
      if (psel_o && !penable_o) begin
        if (last_setup >= 0) chk32("b2b_gap", 32'(i - last_setup), 32'd4);
        last_setup = i;
        setups++;
      end
      if (rsp_valid_o) rsps++;
      if (i % 4 == 0) chk1("b2b_idle_psel_low", psel_o, 1'b0);
      step();
    end
    req_valid_i = 1'b0; rsp_ready_i = 1'b0; pready_i = 1'b0;
    chk32("b2b_setups", 32'(setups), 32'd4);
    chk32("b2b_rsps", 32'(rsps), 32'd4);
    step();

    for (int i = 0; i < 20; i++) begin
      v.addr   = $urandom;
      v.write  = 1'($urandom);
      v.wdata  = $urandom;
      v.waits  = int'($urandom_range(0, 20));
      v.slverr = 1'($urandom);
      v.prdata = $urandom;
      v.dly    = int'($urandom_range(0, 3));
      v = model(v);
      xfer(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
